// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU function codes and issue-FSM state encoding for the ALU issue stage.
package alu_issue_ctrl_pkg;

  localparam int unsigned FUNC_W = 3;

  localparam logic [FUNC_W-1:0] ALU_ADD = 3'd0;
  localparam logic [FUNC_W-1:0] ALU_SUB = 3'd1;
  localparam logic [FUNC_W-1:0] ALU_AND = 3'd2;
  localparam logic [FUNC_W-1:0] ALU_OR  = 3'd3;
  localparam logic [FUNC_W-1:0] ALU_XOR = 3'd4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StWb    = 2'd3
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_cmd_fifo.sv
// Synchronous show-ahead command FIFO; DEPTH must be a power of 2 so pointers wrap naturally.
module alu_issue_ctrl_cmd_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | do_pop);

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: buffers register-addressed commands, reads operands, issues one op at a time
// to the ALU and writes the result back into the local register file.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned NREGS      = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned AW         = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_func,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_ra,
  input  logic [AW-1:0]     cmd_rb,
  input  logic              host_wr_en,
  output logic              host_wr_ready,
  input  logic [AW-1:0]     host_wr_addr,
  input  logic [DWIDTH-1:0] host_wr_data,
  input  logic [AW-1:0]     host_rd_addr,
  output logic [DWIDTH-1:0] host_rd_data,
  output logic              alu_en,
  output logic [2:0]        alu_func,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DWIDTH-1:0] alu_result,
  output logic              busy,
  output logic              wb_pulse,
  output logic              err_timeout
);

  localparam int unsigned FW = FUNC_W + 3 * AW;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WaitLast = CW'(TIMEOUT - 1);

  state_e            state;
  logic [DWIDTH-1:0] rf [NREGS];
  logic [AW-1:0]     rd_q;
  logic [DWIDTH-1:0] result_q;
  logic [CW-1:0]     wait_cnt;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_din;
  logic [FW-1:0]     fifo_dout;
  logic [2:0]        head_func;
  logic [AW-1:0]     head_rd;
  logic [AW-1:0]     head_ra;
  logic [AW-1:0]     head_rb;

  assign cmd_ready = ~fifo_full;
  assign fifo_push = cmd_valid & cmd_ready;
  assign fifo_pop  = (state == StIdle) & ~fifo_empty;
  assign fifo_din  = {cmd_func, cmd_rd, cmd_ra, cmd_rb};
  assign {head_func, head_rd, head_ra, head_rb} = fifo_dout;

  alu_issue_ctrl_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy          = (state != StIdle) | ~fifo_empty;
  assign host_wr_ready = (state != StWb);
  assign host_rd_data  = rf[host_rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= StIdle;
      alu_en      <= 1'b0;
      alu_func    <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      rd_q        <= '0;
      result_q    <= '0;
      wait_cnt    <= '0;
      wb_pulse    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      alu_en   <= 1'b0;
      wb_pulse <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!fifo_empty) begin
            alu_func <= head_func;
            rd_q     <= head_rd;
            alu_a    <= rf[head_ra];
            alu_b    <= rf[head_rb];
            alu_en   <= 1'b1;
            state    <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt <= '0;
          state    <= StWait;
        end
        StWait: begin
          if (alu_done) begin
            result_q <= alu_result;
            wb_pulse <= 1'b1;
            state    <= StWb;
          end else if (wait_cnt == WaitLast) begin
            // Give up on the op; the destination register keeps its old value.
            err_timeout <= 1'b1;
            state       <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        StWb: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Single write port: writeback wins, host writes are refused during WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf[i] <= '0;
      end
    end else if (state == StWb) begin
      rf[rd_q] <= result_q;
    end else if (host_wr_en) begin
      rf[host_wr_addr] <= host_wr_data;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural 1-cycle ALU plus a sequential register-file model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_func;
  logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
  logic        host_wr_en;
  logic        host_wr_ready;
  logic [2:0]  host_wr_addr;
  logic [15:0] host_wr_data;
  logic [2:0]  host_rd_addr;
  logic [15:0] host_rd_data;
  logic        alu_en;
  logic [2:0]  alu_func;
  logic [15:0] alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy, wb_pulse, err_timeout;

  alu_issue_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_func      (cmd_func),
    .cmd_rd        (cmd_rd),
    .cmd_ra        (cmd_ra),
    .cmd_rb        (cmd_rb),
    .host_wr_en    (host_wr_en),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_rd_addr  (host_rd_addr),
    .host_rd_data  (host_rd_data),
    .alu_en        (alu_en),
    .alu_func      (alu_func),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_done      (alu_done),
    .alu_result    (alu_result),
    .busy          (busy),
    .wb_pulse      (wb_pulse),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          issue_cyc[$];
  int          wb_cyc[$];
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [15:0] ref_rf [8];
  bit          hang = 1'b0;
  int          accepted = 0;
  int          first_wait_idx = -1;
  int          wr_retries = 0;
  bit          wr_ready_at_start = 1'b0;

  function automatic logic [15:0] ref_alu(input logic [2:0] f, input logic [15:0] a,
                                          input logic [15:0] b);
    case (f)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural ALU: one-cycle latency, can be stalled forever via hang.
  always @(posedge clk) begin
    if (rst) begin
      alu_done   <= 1'b0;
      alu_result <= 16'h0000;
    end else begin
      alu_done   <= alu_en & ~hang;
      alu_result <= ref_alu(alu_func, alu_a, alu_b);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for issued operations.
  always @(negedge clk) begin
    if (!rst && alu_en) begin
      issue_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("issue_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("issue_func", alu_func, mon_e.f);
        chk("issue_a", alu_a, mon_e.a);
        chk("issue_b", alu_b, mon_e.b);
      end
    end
    if (!rst && wb_pulse) wb_cyc.push_back(cyc);
  end

  task automatic model_push(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] ra,
                            input logic [2:0] rb, input bit drop);
    exp_t e;
    e.f = f;
    e.a = ref_rf[ra];
    e.b = ref_rf[rb];
    exp_q.push_back(e);
    if (!drop) ref_rf[rd] = ref_alu(f, e.a, e.b);
  endtask

  task automatic push_cmd(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] ra,
                          input logic [2:0] rb, input bit drop, input bit hold);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_func  = f;
    cmd_rd    = rd;
    cmd_ra    = ra;
    cmd_rb    = rb;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("push_accept", cmd_ready, 1);
    if (n > 0 && first_wait_idx < 0) first_wait_idx = accepted;
    accepted++;
    model_push(f, rd, ra, rb, drop);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic host_write(input logic [2:0] addr, input logic [15:0] data);
    int n = 0;
    host_wr_en        = 1'b1;
    host_wr_addr      = addr;
    host_wr_data      = data;
    wr_ready_at_start = host_wr_ready;
    while (!host_wr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    wr_retries = n;
    ref_rf[addr] = data;
    @(negedge clk);
    host_wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic wait_issue();
    int n = 0;
    while (!alu_en && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_seen", alu_en, 1);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      host_rd_addr = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), host_rd_data, ref_rf[i]);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_alu_en", alu_en, 0);
    chk("rst_alu_func", alu_func, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_wb_pulse", wb_pulse, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_host_wr_ready", host_wr_ready, 1);
    check_regs("rst");
  endtask

  initial begin
    int t;
    int base;
    logic [2:0] rd;

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_func = '0;
    cmd_rd = '0;
    cmd_ra = '0;
    cmd_rb = '0;
    host_wr_en = 1'b0;
    host_wr_addr = '0;
    host_wr_data = '0;
    host_rd_addr = '0;
    @(negedge clk);
    do_reset();
    check_reset_outputs();

    // Reset in the middle of a stalled WAIT.
    host_write(3'd1, 16'h1234);
    hang = 1'b1;
    push_cmd(ALU_ADD, 3'd2, 3'd1, 3'd1, 1'b1, 1'b0);
    wait_issue();
    repeat (3) @(negedge clk);
    do_reset();
    hang = 1'b0;
    check_reset_outputs();

    // Single ADD with latency checks.
    issue_cyc.delete();
    wb_cyc.delete();
    host_write(3'd1, 16'h0005);
    host_write(3'd2, 16'h0003);
    push_cmd(ALU_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0);
    t = cyc;
    wait_idle();
    chk("add_issue_count", issue_cyc.size(), 1);
    chk("add_issue_cyc", issue_cyc[0], t + 1);
    chk("add_wb_cyc", wb_cyc[0], t + 3);
    chk("add_r3_const", ref_rf[3], 16'h0008);
    check_regs("add");

    // Dependent chain.
    issue_cyc.delete();
    push_cmd(ALU_SUB, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0);
    push_cmd(ALU_AND, 3'd5, 3'd4, 3'd2, 1'b0, 1'b0);
    wait_idle();
    chk("chain_issue_count", issue_cyc.size(), 2);
    chk("chain_spacing", issue_cyc[1] - issue_cyc[0], 4);
    host_rd_addr = 3'd4;
    #1 chk("chain_r4", host_rd_data, 16'h0002);
    host_rd_addr = 3'd5;
    #1 chk("chain_r5", host_rd_data, 16'h0002);
    @(negedge clk);
    check_regs("chain");

    // Backpressure burst of 6 random commands, valid held throughout.
    for (int i = 0; i < 8; i++) host_write(3'(i), 16'($urandom));
    wait_idle();
    issue_cyc.delete();
    accepted = 0;
    first_wait_idx = -1;
    for (int i = 0; i < 6; i++) begin
      push_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom), 1'b0,
               i < 5);
    end
    wait_idle();
    chk("bp_first_stall", first_wait_idx, 5);
    chk("bp_issue_count", issue_cyc.size(), 6);
    for (int i = 1; i < 6; i++) chk("bp_spacing", issue_cyc[i] - issue_cyc[i-1], 4);
    check_regs("bp");

    // Randomized stream.
    for (int i = 0; i < 16; i++) begin
      push_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom), 1'b0,
               1'b0);
    end
    wait_idle();
    check_regs("rand");

    // Timeout: ALU never answers.
    hang = 1'b1;
    rd = 3'($urandom);
    push_cmd(ALU_XOR, rd, 3'($urandom), 3'($urandom), 1'b1, 1'b0);
    wait_issue();
    repeat (15) @(negedge clk);
    chk("to_not_yet", err_timeout, 0);
    @(negedge clk);
    chk("to_fired", err_timeout, 1);
    hang = 1'b0;
    wait_idle();
    check_regs("to_drop");
    push_cmd(ALU_OR, rd, 3'($urandom), 3'($urandom), 1'b0, 1'b0);
    wait_idle();
    check_regs("to_next");
    chk("to_sticky", err_timeout, 1);

    // Host write colliding with writeback.
    base = 0;
    push_cmd(ALU_ADD, 3'd7, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 5)), 1'b0, 1'b0);
    while (!wb_pulse && base < 50) begin
      @(negedge clk);
      base++;
    end
    chk("conf_wb_seen", wb_pulse, 1);
    chk("conf_ready_low", host_wr_ready, 0);
    host_write(3'd6, 16'($urandom));
    chk("conf_ready_at_start", wr_ready_at_start, 0);
    chk("conf_retries", wr_retries, 1);
    wait_idle();
    check_regs("conf");

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
